// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pipe_pkg
//  Purpose  : Shared types and constants for the MIPS pipeline control logic.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int LEN_REG_FILE_ADDR = 5;
    localparam int ZERO_REG          = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Purpose  : Combinational load-use hazard detection between ID and EX.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int LEN_REG_FILE_ADDR = mips_pipe_pkg::LEN_REG_FILE_ADDR
) (
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rs,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rt,
    input  logic                         id_uses_rt,
    input  logic                         ex_mem_read,
    input  logic [LEN_REG_FILE_ADDR-1:0] ex_write_reg,
    output logic                         load_use
);
    import mips_pipe_pkg::*;

    localparam logic [LEN_REG_FILE_ADDR-1:0] c_zero_reg = LEN_REG_FILE_ADDR'(ZERO_REG);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (ex_write_reg == id_rs);
    assign w_rt_match = id_uses_rt && (ex_write_reg == id_rt);

    // Writes to the zero register are discarded, so they never create a dependency.
    assign load_use = ex_mem_read && (ex_write_reg != c_zero_reg) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Stall/flush controller for the 5-stage MIPS pipeline, including
//             data-memory handshake with timeout and a stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int LEN_REG_FILE_ADDR = mips_pipe_pkg::LEN_REG_FILE_ADDR,
    parameter int MEM_TIMEOUT       = 15,
    parameter int LEN_TIMEOUT       = 4,
    parameter int LEN_STALL_CNT     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rs,
    input  logic [LEN_REG_FILE_ADDR-1:0] id_rt,
    input  logic                         id_uses_rt,
    input  logic                         ex_mem_read,
    input  logic [LEN_REG_FILE_ADDR-1:0] ex_write_reg,
    input  logic                         ex_branch_taken,
    input  logic                         mem_access,
    input  logic                         dmem_ack,
    output logic                         dmem_req,
    output logic                         pc_en,
    output logic                         if2id_en,
    output logic                         id2ex_en,
    output logic                         ex2m_en,
    output logic                         m2wb_en,
    output logic                         if2id_flush,
    output logic                         id2ex_flush,
    output logic                         mem_timeout,
    output logic [LEN_STALL_CNT-1:0]     stall_cnt
);
    import mips_pipe_pkg::*;

    ctrl_state_t              r_state;
    ctrl_state_t              w_next_state;
    logic [LEN_TIMEOUT-1:0]   r_timeout;
    logic                     w_timeout_inc;
    logic [LEN_STALL_CNT-1:0] r_stall_cnt;
    logic                     w_load_use;

    hazard_detect #(
        .LEN_REG_FILE_ADDR (LEN_REG_FILE_ADDR)
    ) u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .load_use     (w_load_use)
    );

    always_comb begin
        w_next_state  = r_state;
        w_timeout_inc = 1'b0;
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if2id_en      = 1'b0;
        id2ex_en      = 1'b0;
        ex2m_en       = 1'b0;
        m2wb_en       = 1'b0;
        if2id_flush   = 1'b0;
        id2ex_flush   = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    // A memory access freezes everything; branch/hazard wait until release.
                    if (mem_access) begin
                        w_next_state = MEM_WAIT;
                    end else begin
                        pc_en    = 1'b1;
                        if2id_en = 1'b1;
                        id2ex_en = 1'b1;
                        ex2m_en  = 1'b1;
                        m2wb_en  = 1'b1;
                        if (ex_branch_taken) begin
                            if2id_flush = 1'b1;
                            id2ex_flush = 1'b1;
                        end else if (w_load_use) begin
                            pc_en       = 1'b0;
                            if2id_en    = 1'b0;
                            id2ex_flush = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        pc_en        = 1'b1;
                        if2id_en     = 1'b1;
                        id2ex_en     = 1'b1;
                        ex2m_en      = 1'b1;
                        m2wb_en      = 1'b1;
                        w_next_state = RUN;
                    end else if (r_timeout == LEN_TIMEOUT'(MEM_TIMEOUT)) begin
                        w_next_state = ERROR;
                    end else begin
                        w_timeout_inc = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ERROR;
                end
            endcase
        end
    end

    assign mem_timeout = (r_state == ERROR);
    assign stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_timeout   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            // Held at zero in RUN so every MEM_WAIT episode starts a fresh count.
            if (r_state == RUN) begin
                r_timeout <= '0;
            end else if (w_timeout_inc) begin
                r_timeout <= r_timeout + 1'b1;
            end
            if (!pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Directed self-checking testbench for pipeline_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    // {pc_en, if2id_en, id2ex_en, ex2m_en, m2wb_en, if2id_flush, id2ex_flush}
    localparam logic [6:0] CTL_FREEZE = 7'b0000000;
    localparam logic [6:0] CTL_RUN    = 7'b1111100;
    localparam logic [6:0] CTL_LU     = 7'b0011101;
    localparam logic [6:0] CTL_BR     = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_write_reg = '0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_access = 1'b0;
    logic       dmem_ack = 1'b0;

    logic        dmem_req, pc_en, if2id_en, id2ex_en, ex2m_en, m2wb_en;
    logic        if2id_flush, id2ex_flush, mem_timeout;
    logic [31:0] stall_cnt;
    logic        s_dmem_req, s_pc_en, s_if2id_en, s_id2ex_en, s_ex2m_en, s_m2wb_en;
    logic        s_if2id_flush, s_id2ex_flush, s_mem_timeout;
    logic [3:0]  s_stall_cnt;
    logic [6:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

    assign ctl = {pc_en, if2id_en, id2ex_en, ex2m_en, m2wb_en, if2id_flush, id2ex_flush};

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk (clk), .reset (reset), .id_rs (id_rs), .id_rt (id_rt),
        .id_uses_rt (id_uses_rt), .ex_mem_read (ex_mem_read), .ex_write_reg (ex_write_reg),
        .ex_branch_taken (ex_branch_taken), .mem_access (mem_access), .dmem_ack (dmem_ack),
        .dmem_req (dmem_req), .pc_en (pc_en), .if2id_en (if2id_en), .id2ex_en (id2ex_en),
        .ex2m_en (ex2m_en), .m2wb_en (m2wb_en), .if2id_flush (if2id_flush),
        .id2ex_flush (id2ex_flush), .mem_timeout (mem_timeout), .stall_cnt (stall_cnt)
    );

    pipeline_ctrl #(.LEN_STALL_CNT (4)) dut_sat (
        .clk (clk), .reset (reset), .id_rs (id_rs), .id_rt (id_rt),
        .id_uses_rt (id_uses_rt), .ex_mem_read (ex_mem_read), .ex_write_reg (ex_write_reg),
        .ex_branch_taken (ex_branch_taken), .mem_access (mem_access), .dmem_ack (dmem_ack),
        .dmem_req (s_dmem_req), .pc_en (s_pc_en), .if2id_en (s_if2id_en), .id2ex_en (s_id2ex_en),
        .ex2m_en (s_ex2m_en), .m2wb_en (s_m2wb_en), .if2id_flush (s_if2id_flush),
        .id2ex_flush (s_id2ex_flush), .mem_timeout (s_mem_timeout), .stall_cnt (s_stall_cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_write_reg = '0;
        ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        n_vec++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b expected 0", mem_timeout); end
        reset = 1'b0;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL run_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL run_req: got %b expected 0", dmem_req); end
        n_vec++; if (s_stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_reset_cnt: got %0d expected 0", s_stall_cnt); end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
        #1;
        n_vec++; if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_after_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_vec++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        // Destination r0 never stalls.
        ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_r0_ctl: got %b expected %b", ctl, CTL_RUN); end
        // rt match only counts when the instruction reads rt.
        ex_write_reg = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_rt_unused_ctl: got %b expected %b", ctl, CTL_RUN); end
        ex_mem_read = 1'b0; id_uses_rt = 1'b1;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_noload_ctl: got %b expected %b", ctl, CTL_RUN); end
        ex_mem_read = 1'b1;
        #1;
        n_vec++; if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, CTL_LU); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_branch();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
        #1;
        n_vec++; if (ctl !== CTL_BR) begin n_err++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BR); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL br_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1'b1; ex_branch_taken = 1'b1;
        #1;
        n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL mw_detect_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mw_detect_req: got %b expected 0", dmem_req); end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL mw_wait%0d_ctl: got %b expected %b", i, ctl, CTL_FREEZE); end
            n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL mw_wait%0d_req: got %b expected 1", i, dmem_req); end
            tick();
        end
        dmem_ack = 1'b1; ex_branch_taken = 1'b0;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mw_ack_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL mw_ack_req: got %b expected 1", dmem_req); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mw_done_req: got %b expected 0", dmem_req); end
        n_vec++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL mw_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_access = 1'b1;
        tick();
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL b2b_ack1_ctl: got %b expected %b", ctl, CTL_RUN); end
        tick();
        dmem_ack = 1'b0;
        #1;
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL b2b_detect2_req: got %b expected 0", dmem_req); end
        n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL b2b_detect2_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        tick();
        dmem_ack = 1'b1;
        #1;
        n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL b2b_ack2_req: got %b expected 1", dmem_req); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL b2b_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_timeout_saturation();
        do_reset();
        mem_access = 1'b1;
        tick();
        mem_access = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_vec++; if (dmem_req !== 1'b1 || mem_timeout !== 1'b0) begin
                n_err++; $display("FAIL tmo_wait%0d: got req=%b tmo=%b expected req=1 tmo=0", i, dmem_req, mem_timeout);
            end
            tick();
        end
        n_vec++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b expected 1", mem_timeout); end
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL tmo_req: got %b expected 0", dmem_req); end
        n_vec++; if (stall_cnt !== 32'd17) begin n_err++; $display("FAIL tmo_cnt: got %0d expected 17", stall_cnt); end
        dmem_ack = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL err_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        n_vec++; if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", mem_timeout); end
        n_vec++; if (stall_cnt !== 32'd37) begin n_err++; $display("FAIL err_cnt: got %0d expected 37", stall_cnt); end
        n_vec++; if (s_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt: got %0d expected 15", s_stall_cnt); end
        do_reset();
        n_vec++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b expected 0", mem_timeout); end
        n_vec++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL tmo_recover_ctl: got %b expected %b", ctl, CTL_RUN); end
        n_vec++; if (s_stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clear: got %0d expected 0", s_stall_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_access = 1'b1;
        tick();
        tick();
        #1;
        n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rmw_req_before: got %b expected 1", dmem_req); end
        reset = 1'b1;
        #1;
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rmw_req_drop: got %b expected 0", dmem_req); end
        n_vec++; if (ctl !== CTL_FREEZE) begin n_err++; $display("FAIL rmw_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        n_vec++; if (ctl !== CTL_RUN || dmem_req !== 1'b0) begin
            n_err++; $display("FAIL rmw_run: got ctl=%b req=%b expected ctl=%b req=0", ctl, dmem_req, CTL_RUN);
        end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rmw_cnt: got %0d expected 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout_saturation();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
